// File: rtl/txpkt_sync_fifo_pkg.sv
// Shared definitions for the lmac packet FIFOs: write-side FSM states and the drop counter.
package lmac_fifo_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_INPKT = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_e;

    localparam int DROPCNT_W = 16;
    localparam logic [DROPCNT_W-1:0] DROPCNT_MAX = {DROPCNT_W{1'b1}};

    function automatic logic [DROPCNT_W-1:0] dropcnt_inc(input logic [DROPCNT_W-1:0] v);
        return (v == DROPCNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/txpkt_sync_fifo_if.sv
// Write/read handshake and status bundle of the packet FIFO.
// master = the client driving writes and reads, slave = the FIFO.
interface txpkt_sync_fifo_if #(
    parameter int WIDTH = 64,
    parameter int PTR   = 8
);
    import lmac_fifo_pkg::*;

    logic                 wren;
    logic [WIDTH-1:0]     datain;
    logic                 eopin;
    logic                 abort;
    logic                 wrfull;
    logic                 wrafull;
    logic [PTR:0]         wrusedw;
    logic                 rden;
    logic [WIDTH-1:0]     dataout;
    logic                 eopout;
    logic                 rdempty;
    logic [PTR:0]         rdusedw;
    logic [PTR:0]         pktcnt;
    logic [DROPCNT_W-1:0] dropcnt;
    logic                 dbg;

    modport master (
        output wren, datain, eopin, abort, rden,
        input  wrfull, wrafull, wrusedw, dataout, eopout, rdempty, rdusedw, pktcnt, dropcnt, dbg
    );

    modport slave (
        input  wren, datain, eopin, abort, rden,
        output wrfull, wrafull, wrusedw, dataout, eopout, rdempty, rdusedw, pktcnt, dropcnt, dbg
    );

endinterface

// File: rtl/txpkt_sync_fifo_ram.sv
// Simple dual-port RAM, one write and one read port on the same clock.
// Latency: rdata_o valid one cycle after re_i and held until the next read; no backpressure.
// Backpressure: none, the caller guarantees address validity.
module fifo_ram_sdp #(
    parameter int W     = 65,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Storage has no reset so it maps onto block RAM; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/txpkt_sync_fifo.sv
// Packet FIFO with speculative/committed write pointers; TXPKT_SYNC_FIFO_ERRCHK_EN adds a sticky dbg error flag.
// Latency: a committed word (any written word in cut-through) is readable next cycle; dataout 1 cycle after rden.
// Backpressure: a write hitting wrfull drops the whole packet (DROP until eop); rden on rdempty is ignored.
module txpkt_sync_fifo
    import lmac_fifo_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 256,
    parameter int PTR       = 8,
    parameter int AFULL_LVL = 240,
    parameter int STORE_FWD = 1
) (
    input  logic              clk,
    input  logic              reset_,
    txpkt_sync_fifo_if.slave  fifo_if
);

    localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AFULL_W = (PTR+1)'(AFULL_LVL);

    wr_state_e            state_q, state_d;
    logic [PTR:0]         wsp_q, wsp_d;
    logic [PTR:0]         wcp_q, wcp_d;
    logic [PTR:0]         rp_q, rp_d;
    logic [PTR:0]         pkt_q, pkt_d;
    logic [DROPCNT_W-1:0] drop_q, drop_d;
    logic                 rd_vld_q;

    logic [PTR:0]         occ;
    logic [PTR:0]         rd_limit;
    logic [PTR:0]         rd_avail;
    logic                 full;
    logic                 empty;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 commit;
    logic                 drop_evt;
    logic                 pkt_dec;
    logic [PTR:0]         rp_ahead;
    logic [PTR:0]         wsp_ahead;
    logic [PTR:0]         rewind_ptr;
    logic [WIDTH:0]       rd_word;

    assign occ      = wsp_q - rp_q;
    assign rd_limit = (STORE_FWD != 0) ? wcp_q : wsp_q;
    assign rd_avail = rd_limit - rp_q;
    assign full     = (occ == DEPTH_W);
    assign empty    = (rd_avail == '0);
    assign rd_acc   = fifo_if.rden && !empty;

    // In cut-through the reader may already have consumed part of the packet being
    // discarded; the rewind then stops at rp so occupancy never goes negative.
    assign rp_ahead   = rp_q - wcp_q;
    assign wsp_ahead  = wsp_q - wcp_q;
    assign rewind_ptr = ((STORE_FWD == 0) && (rp_ahead <= wsp_ahead)) ? rp_q : wcp_q;

    always_comb begin
        state_d  = state_q;
        wsp_d    = wsp_q;
        wcp_d    = wcp_q;
        wr_acc   = 1'b0;
        commit   = 1'b0;
        drop_evt = 1'b0;
        unique case (state_q)
            WR_IDLE, WR_INPKT: begin
                if ((state_q == WR_INPKT) && fifo_if.abort) begin
                    wsp_d    = rewind_ptr;
                    wcp_d    = rewind_ptr;
                    drop_evt = 1'b1;
                    state_d  = WR_IDLE;
                end else if (fifo_if.wren && full) begin
                    // A refused eop word ends its packet right here, so there is nothing left to skip.
                    wsp_d    = rewind_ptr;
                    wcp_d    = rewind_ptr;
                    drop_evt = 1'b1;
                    state_d  = fifo_if.eopin ? WR_IDLE : WR_DROP;
                end else if (fifo_if.wren) begin
                    wr_acc = 1'b1;
                    wsp_d  = wsp_q + 1'b1;
                    if (fifo_if.eopin) begin
                        wcp_d   = wsp_q + 1'b1;
                        commit  = 1'b1;
                        state_d = WR_IDLE;
                    end else begin
                        state_d = WR_INPKT;
                    end
                end
            end
            WR_DROP: begin
                if (fifo_if.wren && fifo_if.eopin) begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // A packet leaves the count when its eop word appears on eopout.
    assign pkt_dec = rd_vld_q && rd_word[WIDTH];

    always_comb begin
        rp_d   = rd_acc ? rp_q + 1'b1 : rp_q;
        drop_d = drop_evt ? dropcnt_inc(drop_q) : drop_q;
        pkt_d  = pkt_q;
        unique case ({commit, pkt_dec})
            2'b10:   pkt_d = pkt_q + 1'b1;
            2'b01:   pkt_d = pkt_q - 1'b1;
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= WR_IDLE;
            wsp_q    <= '0;
            wcp_q    <= '0;
            rp_q     <= '0;
            pkt_q    <= '0;
            drop_q   <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wsp_q    <= wsp_d;
            wcp_q    <= wcp_d;
            rp_q     <= rp_d;
            pkt_q    <= pkt_d;
            drop_q   <= drop_d;
            rd_vld_q <= rd_acc;
        end
    end

    fifo_ram_sdp #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (PTR)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_),
        .we_i    (wr_acc),
        .waddr_i (wsp_q[PTR-1:0]),
        .wdata_i ({fifo_if.eopin, fifo_if.datain}),
        .re_i    (rd_acc),
        .raddr_i (rp_q[PTR-1:0]),
        .rdata_o (rd_word)
    );

    assign fifo_if.dataout = rd_word[WIDTH-1:0];
    assign fifo_if.eopout  = rd_word[WIDTH];
    assign fifo_if.wrfull  = full;
    assign fifo_if.wrafull = (occ >= AFULL_W);
    assign fifo_if.wrusedw = occ;
    assign fifo_if.rdempty = empty;
    assign fifo_if.rdusedw = rd_avail;
    assign fifo_if.pktcnt  = pkt_q;
    assign fifo_if.dropcnt = drop_q;

`ifdef TXPKT_SYNC_FIFO_ERRCHK_EN
    logic dbg_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            dbg_q <= 1'b0;
        end else if ((fifo_if.rden && empty) || (fifo_if.wren && (state_q == WR_DROP))) begin
            dbg_q <= 1'b1;
        end
    end

    assign fifo_if.dbg = dbg_q;
`else
    assign fifo_if.dbg = 1'b0;
`endif

endmodule

// File: tb/tb_txpkt_sync_fifo.sv
// Bench for txpkt_sync_fifo: a store-and-forward instance against a queue-based packet model,
// plus directed cut-through checks on a second instance.
module tb_txpkt_sync_fifo;
    import lmac_fifo_pkg::*;

    localparam int WIDTH = 64;
    localparam int DEPTH = 256;
    localparam int PTR   = 8;
    localparam int AFULL = 240;

    logic clk    = 1'b0;
    logic reset_ = 1'b1;
    always #5 clk = ~clk;

    txpkt_sync_fifo_if #(.WIDTH(WIDTH), .PTR(PTR)) sf_if ();
    txpkt_sync_fifo_if #(.WIDTH(WIDTH), .PTR(PTR)) ct_if ();

    txpkt_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .AFULL_LVL(AFULL), .STORE_FWD(1)) u_sf (
        .clk(clk), .reset_(reset_), .fifo_if(sf_if));
    txpkt_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .AFULL_LVL(AFULL), .STORE_FWD(0)) u_ct (
        .clk(clk), .reset_(reset_), .fifo_if(ct_if));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: committed packets in m_store, the packet being written in m_cur.
    typedef struct packed { logic eop; logic [63:0] d; } word_t;
    word_t m_store[$];
    word_t m_cur[$];
    bit    m_inpkt, m_drop, m_lag, m_dbg;
    int    m_drops;
    word_t m_out;

    function automatic int store_eops();
        int n = 0;
        foreach (m_store[i]) if (m_store[i].eop) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_store.delete(); m_cur.delete();
        m_inpkt = 0; m_drop = 0; m_lag = 0; m_dbg = 0;
        m_drops = 0; m_out = '0;
    endtask

    task automatic model_step(input bit w, input logic [63:0] d, input bit e, input bit a, input bit r);
        int occ;
        bit full;
        occ  = m_store.size() + m_cur.size();
        full = (occ == DEPTH);
`ifdef TXPKT_SYNC_FIFO_ERRCHK_EN
        if ((r && m_store.size() == 0) || (w && m_drop)) m_dbg = 1;
`endif
        m_lag = 0;
        if (r && m_store.size() > 0) begin
            m_out = m_store.pop_front();
            m_lag = m_out.eop;
        end
        if (m_inpkt && a) begin
            m_cur.delete(); m_inpkt = 0;
            if (m_drops < 65535) m_drops++;
        end else if (m_drop) begin
            if (w && e) m_drop = 0;
        end else if (w && full) begin
            m_cur.delete(); m_inpkt = 0; m_drop = !e;
            if (m_drops < 65535) m_drops++;
        end else if (w) begin
            m_cur.push_back({e, d});
            if (e) begin
                foreach (m_cur[i]) m_store.push_back(m_cur[i]);
                m_cur.delete();
                m_inpkt = 0;
            end else begin
                m_inpkt = 1;
            end
        end
    endtask

    task automatic compare_all();
        int occ;
        occ = m_store.size() + m_cur.size();
        chk("wrusedw", sf_if.wrusedw, occ);
        chk("rdusedw", sf_if.rdusedw, m_store.size());
        chk("rdempty", sf_if.rdempty, m_store.size() == 0);
        chk("wrfull",  sf_if.wrfull,  occ == DEPTH);
        chk("wrafull", sf_if.wrafull, occ >= AFULL);
        chk("dropcnt", sf_if.dropcnt, m_drops);
        chk("dataout", sf_if.dataout, m_out.d);
        chk("eopout",  sf_if.eopout,  m_out.eop);
        chk("pktcnt",  sf_if.pktcnt,  store_eops() + int'(m_lag));
        chk("dbg",     sf_if.dbg,     m_dbg);
    endtask

    task automatic cyc(input bit w, input logic [63:0] d, input bit e, input bit a, input bit r);
        sf_if.wren = w; sf_if.datain = d; sf_if.eopin = e; sf_if.abort = a; sf_if.rden = r;
        @(posedge clk);
        model_step(w, d, e, a, r);
        @(negedge clk);
        sf_if.wren = 0; sf_if.eopin = 0; sf_if.abort = 0; sf_if.rden = 0;
        compare_all();
    endtask

    task automatic ct_cyc(input bit w, input logic [63:0] d, input bit e, input bit a, input bit r);
        ct_if.wren = w; ct_if.datain = d; ct_if.eopin = e; ct_if.abort = a; ct_if.rden = r;
        @(posedge clk);
        @(negedge clk);
        ct_if.wren = 0; ct_if.eopin = 0; ct_if.abort = 0; ct_if.rden = 0;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        reset_ = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w1, w2, w3, w4, w5, dat;
        int pos, sent, guard, af_lvl;
        bit af_seen, wr, rd, ab;

        sf_if.wren = 0; sf_if.datain = '0; sf_if.eopin = 0; sf_if.abort = 0; sf_if.rden = 0;
        ct_if.wren = 0; ct_if.datain = '0; ct_if.eopin = 0; ct_if.abort = 0; ct_if.rden = 0;
        model_reset();
        @(negedge clk);

        // Store-and-forward: nothing readable until the eop word commits the packet.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 64'hA000_0000_0000_0000 | 64'(i), i == 4, 0, 0);
            if (i < 4) chk("sf_empty_before_eop", sf_if.rdempty, 1);
        end
        chk("sf_empty_after_eop", sf_if.rdempty, 0);
        chk("sf_pktcnt", sf_if.pktcnt, 1);
        chk("sf_rdusedw", sf_if.rdusedw, 4);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, '0, 0, 0, 1);
            chk("sf_readback", sf_if.dataout, 64'hA000_0000_0000_0000 | 64'(i));
        end
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 0);
        chk("sf_pkt_drained", sf_if.pktcnt, 0);

        // Abort discards the partial packet; abort while idle is ignored.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 64'hB0 + 64'(i), 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        chk("abort_wrusedw", sf_if.wrusedw, 0);
        chk("abort_dropcnt", sf_if.dropcnt, 1);
        chk("abort_rdempty", sf_if.rdempty, 1);
        cyc(0, '0, 0, 1, 0);
        chk("abort_idle_ignored", sf_if.dropcnt, 1);

        // Overflow: word 257 of a 300-word packet hits full and the packet is dropped.
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            cyc(1, 64'(i), i == 300, 0, 0);
            if (i == 256) chk("ovf_full_at_256", sf_if.wrfull, 1);
            if (i == 257) begin
                chk("ovf_wrusedw", sf_if.wrusedw, 0);
                chk("ovf_dropcnt", sf_if.dropcnt, 1);
            end
        end
        cyc(1, 64'hC1, 0, 0, 0);
        cyc(1, 64'hC2, 1, 0, 0);
        cyc(0, '0, 0, 0, 1);
        chk("ovf_next_w0", sf_if.dataout, 64'hC1);
        cyc(0, '0, 0, 0, 1);
        chk("ovf_next_w1", sf_if.dataout, 64'hC2);
        chk("ovf_next_eop", sf_if.eopout, 1);
        chk("ovf_dropcnt_final", sf_if.dropcnt, 1);

        // Random stream of 10-word packets with random reads and occasional aborts.
        do_reset();
        pos = 0; sent = 0; guard = 0; af_seen = 0; af_lvl = 0;
        while (sent < 1000 && guard < 20000) begin
            guard++;
            ab = ($urandom_range(0, 99) == 0);
            wr = !ab && ($urandom_range(0, 9) < 9);
            rd = ($urandom_range(0, 3) == 0);
            dat = {$urandom, $urandom};
            cyc(wr, dat, wr && (pos == 9), ab, rd);
            if (wr) begin pos = (pos + 1) % 10; sent++; end
            if (ab) pos = 0;
            if (!af_seen && sf_if.wrafull) begin
                af_seen = 1;
                af_lvl  = m_store.size() + m_cur.size();
            end
        end
        chk("stream_done", sent, 1000);
        chk("wrafull_level", af_lvl, AFULL);
        for (int k = 0; k < 600 && m_store.size() > 0; k++) cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 0);
        chk("drain_rdempty", sf_if.rdempty, 1);
        chk("drain_pktcnt", sf_if.pktcnt, 0);

        // Reset in the middle of a packet clears everything, including dropcnt.
        cyc(1, 64'hD0, 0, 0, 0);
        cyc(1, 64'hD1, 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 64'hE0 + 64'(i), 0, 0, 0);
        reset_ = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_dropcnt", sf_if.dropcnt, 0);
        chk("rst_wrusedw", sf_if.wrusedw, 0);
        chk("rst_rdempty", sf_if.rdempty, 1);
        @(negedge clk);
        reset_ = 1'b1;
        cyc(1, 64'hF00D, 1, 0, 0);
        cyc(0, '0, 0, 0, 1);
        chk("rst_after_dout", sf_if.dataout, 64'hF00D);
        chk("rst_after_usedw", sf_if.wrusedw, 0);

        // Cut-through instance.
        do_reset();
        w1 = 64'h1111_0001; w2 = 64'h2222_0002; w3 = 64'h3333_0003;
        w4 = 64'h4444_0004; w5 = 64'h5555_0005;
        ct_cyc(1, w1, 0, 0, 0);
        chk("ct_rdempty_w1", ct_if.rdempty, 0);
        chk("ct_rdusedw_w1", ct_if.rdusedw, 1);
        ct_cyc(1, w2, 0, 0, 1);
        chk("ct_dout_w1", ct_if.dataout, w1);
        ct_cyc(1, w3, 0, 0, 1);
        chk("ct_dout_w2", ct_if.dataout, w2);
        ct_cyc(0, '0, 0, 1, 0);
        chk("ct_abort_wrusedw", ct_if.wrusedw, 0);
        chk("ct_abort_rdempty", ct_if.rdempty, 1);
        chk("ct_abort_dropcnt", ct_if.dropcnt, 1);
        chk("ct_abort_hold", ct_if.dataout, w2);
        ct_cyc(1, w4, 0, 0, 0);
        ct_cyc(1, w5, 1, 0, 0);
        chk("ct_pktcnt_commit", ct_if.pktcnt, 1);
        ct_cyc(0, '0, 0, 0, 1);
        chk("ct_dout_w4", ct_if.dataout, w4);
        ct_cyc(0, '0, 0, 0, 1);
        chk("ct_dout_w5", ct_if.dataout, w5);
        chk("ct_eop_w5", ct_if.eopout, 1);
        ct_cyc(0, '0, 0, 0, 1);
        chk("ct_empty_read_hold", ct_if.dataout, w5);
        chk("ct_empty_rdusedw", ct_if.rdusedw, 0);
        chk("ct_pktcnt_final", ct_if.pktcnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/txpkt_sync_fifo.md
TXPKT_SYNC_FIFO -- requirements
Module: txpkt_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, storage words; power of two.
REQ-003 SHALL have parameter PTR, default 8, log2(DEPTH).
REQ-004 SHALL have parameter AFULL_LVL, default 240, almost-full threshold in words.
REQ-005 SHALL have parameter STORE_FWD, default 1: 1 = store-and-forward, 0 = cut-through.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port wren, input, 1, write request.
REQ-009 SHALL have port datain, input, WIDTH, write data.
REQ-010 SHALL have port eopin, input, 1, last word of packet, qualified by wren.
REQ-011 SHALL have port abort, input, 1, discard the packet currently being written.
REQ-012 SHALL have port wrfull, output, 1, write occupancy == DEPTH.
REQ-013 SHALL have port wrafull, output, 1, write occupancy >= AFULL_LVL.
REQ-014 SHALL have port wrusedw, output, PTR+1, write occupancy (speculative pointer minus read pointer).
REQ-015 SHALL have port rden, input, 1, read request.
REQ-016 SHALL have port dataout, output, WIDTH, registered read data.
REQ-017 SHALL have port eopout, output, 1, registered end-of-packet flag for dataout.
REQ-018 SHALL have port rdempty, output, 1, no readable word.
REQ-019 SHALL have port rdusedw, output, PTR+1, readable words.
REQ-020 SHALL have port pktcnt, output, PTR+1, number of complete packets held.
REQ-021 SHALL have port dropcnt, output, 16, count of dropped packets; saturates at 0xFFFF.

Function
REQ-022 SHALL store {eop, data} per word in a DEPTH x (WIDTH+1) array.
REQ-023 SHALL keep three PTR+1-bit pointers: speculative write (wsp), committed write (wcp), read (rp); each wraps modulo 2*DEPTH.
REQ-024 SHALL implement write FSM IDLE -> INPKT on an accepted non-eop write; INPKT -> IDLE on an accepted eop write or abort; any state -> DROP on wren with wrfull; DROP -> IDLE on wren&eopin.
REQ-025 SHALL, on an accepted write, store at wsp and increment wsp; with eopin, additionally set wcp = wsp+1 in the same cycle.
REQ-026 SHALL, on abort in INPKT, set wsp = wcp and increment dropcnt; abort in IDLE or DROP SHALL be ignored.
REQ-027 SHALL, on entering DROP, set wsp = wcp, increment dropcnt once, and discard every write until eop.
REQ-028 SHALL derive the readable limit from wcp when STORE_FWD=1 and from wsp when STORE_FWD=0; with STORE_FWD=0, abort and DROP rewinds SHALL still apply but SHALL NOT rewind wsp below rp.
REQ-029 SHALL accept rden only when !rdempty, present the word on dataout/eopout one cycle later, and hold dataout otherwise; rden on empty SHALL be ignored.
REQ-030 SHALL increment pktcnt on commit and decrement it when an eop word is read; both events in the same cycle SHALL leave it unchanged.
REQ-031 SHALL allow a simultaneous read and write in every state, including when full (the write is refused) and when empty (the read is refused).

Reset
REQ-032 SHALL, on reset_ low, set all pointers to 0, the FSM to IDLE, dataout to 0, eopout to 0, pktcnt and dropcnt to 0, rdempty to 1, wrfull to 0, wrafull to 0, and usedw to 0; array contents SHALL be undefined.
REQ-033 SHALL discard a packet that is in flight when reset is asserted, without counting it in dropcnt.

Configuration
REQ-034 SHALL, with TXPKT_SYNC_FIFO_ERRCHK_EN defined, add output dbg (1), a sticky flag set on rden while rdempty or wren in DROP, cleared only by reset.
REQ-035 SHALL, without the macro, drive dbg constant 0.

Structure
REQ-036 SHALL place the FSM state enum and the drop-counter width constant in the shared package lmac_fifo_pkg.
REQ-037 SHALL instantiate one sub-module, fifo_ram_sdp, a simple dual-port DEPTH x (WIDTH+1) RAM with registered read.

Verification
REQ-038 SHALL test store-and-forward: write 4 words, eop on the 4th -> rdempty stays 1 until the cycle after the eop write, then pktcnt=1 and rdusedw=4.
REQ-039 SHALL test abort: write 3 words, then assert abort -> wrusedw=0, dropcnt=1, rdempty=1.
REQ-040 SHALL test overflow: a 300-word packet with DEPTH=256 -> DROP entered at word 257, dropcnt=1, wrusedw returns to 0, and a following 2-word packet reads back intact.
REQ-041 SHALL test cut-through (STORE_FWD=0): write word 1 -> rdempty=0 the next cycle, and dataout equals word 1 one cycle after rden.
REQ-042 SHALL test wrap and concurrency: stream 1000 words of 10-word packets with random rden -> data order preserved, pktcnt never negative, wrafull asserts at 240.
REQ-043 SHALL test mid-packet reset: assert reset_ after 5 words -> every output is at its reset value and dropcnt=0.
